downcounter: RTL
================

Name: downcounter

Overview:
Loadable N-bit down counter / interval timer. It is the counterpart of the upcounter: it counts from a loaded value toward zero instead of up from zero. It signals terminal count and supports one-shot and auto-reload operation. It serves as the timeout/interval source for sequencing logic elsewhere in the design.

Parameters:
N, 4, counter width in bits (load value range 0 .. 2^N-1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
en  input  1  count enable; one decrement per enabled cycle while running
load  input  1  load strobe; captures d and mode, starts a new count
d  input  N  load value
mode  input  1  0 = one-shot, 1 = auto-reload; latched on load
q  output  N  current count, registered
tc  output  1  terminal-count pulse, registered, high for exactly one cycle per expiry
busy  output  1  high while in RUN
done  output  1  sticky expiry flag (one-shot only); cleared by load or reset

Behaviour:
- Priority at each rising edge: reset > load > en.
- Reset:
  - q=0, internal reload register=0, latched mode=0, tc=0, busy=0, done=0, state IDLE.
  - Reset mid-count aborts the count immediately; no tc is issued.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- load=1 from any state:
  - q<=d, reload<=d, mode latched, tc<=0, done<=0.
  - d!=0 -> RUN. d==0 -> IDLE (q=0, no tc ever issued).
  - A load in the same cycle as a would-be expiry (q==1, en=1) wins: the count restarts and no tc is issued.
- RUN, en=1, q>1: q<=q-1, tc<=0.
- RUN, en=1, q==1 (expiry):
  - tc<=1 for the following cycle only.
  - One-shot: q<=0, state DONE.
  - Auto-reload: q<=reload, stay RUN.
  - Auto-reload period is exactly reload enabled cycles from one tc to the next.
- RUN, en=0: q holds, tc<=0. Stalls extend the count and never lose state.
- IDLE and DONE:
  - en is ignored; q holds (0).
  - The counter never decrements below 0 and never wraps to 2^N-1.
- tc is never high for two consecutive cycles, except auto-reload with reload==1 and en held high, where tc stays high continuously (expiry every cycle).
- Latency:
  - q reflects d one cycle after the load edge.
  - From load of value L with en held high, tc is high in the cycle following the L-th enabled edge after the load edge.
- Width: all arithmetic is modulo N bits. Maximum load 2^N-1 gives 2^N-1 enabled cycles to expiry.
- Changing mode or d while running has no effect until the next load.

Test Plan:
- Reset for 2 cycles with load=1, en=1, d=4'hF -> q=0, tc=0, busy=0, done=0 throughout reset and on the first cycle after release.
- One-shot, load d=5, mode=0, en held high -> q sequence 5,4,3,2,1,0; tc high exactly one cycle coincident with q=0; busy falls and done rises on the same cycle; q stays 0 for 20 further cycles.
- Auto-reload, load d=3, mode=1, en high for 12 cycles -> q cycles 3,2,1,3,2,1,...; tc pulses every 3rd cycle (4 pulses); done stays 0.
- Stall: one-shot load d=4, en toggled 1,0,0,1,1,0,1 -> q only decrements on en=1 cycles; tc on the 4th enabled edge; no change while en=0.
- Collision: auto-reload reload=2; at q==1 with en=1, assert load with d=7 -> q=7 next cycle, no tc pulse; reset asserted when q==1, en=1 -> q=0, no tc.
- Edge values: load d=0 -> IDLE, no tc, busy=0; load d=4'hF one-shot -> tc after exactly 15 enabled cycles; auto-reload d=1 -> tc high every cycle, q stays 1.

Source files
------------

// File: rtl/downcounter.sv
// downcounter: loadable N-bit down counter / interval timer.
//
// Counts from a loaded value toward zero, one step per enabled cycle while
// running. Raises a one-cycle terminal-count pulse on each expiry. In one-shot
// mode it then parks at zero with a sticky done flag. In auto-reload mode it
// restarts from the loaded value.
//
// State table
//   state | meaning
//   IDLE  | no count in progress; q holds 0; en ignored
//   RUN   | counting down on en; busy=1
//   DONE  | one-shot count expired; q holds 0; done=1; en ignored
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   en     in   count enable
//   load   in   load strobe (captures d and mode, starts a new count)
//   d      in   [N-1:0] load value
//   mode   in   0 = one-shot, 1 = auto-reload (latched on load)
//   q      out  [N-1:0] current count, registered
//   tc     out  terminal-count pulse, registered
//   busy   out  high while in RUN
//   done   out  sticky one-shot expiry flag
module downcounter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         mode,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [N-1:0] reload;
  logic         mode_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
      mode_r <= 1'b0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      // A load always wins over a coincident expiry, so no tc here.
      q      <= d;
      reload <= d;
      mode_r <= mode;
      tc     <= 1'b0;
      done   <= 1'b0;
      if (d != '0) begin
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (q == '0) begin
            // Unreachable in normal operation; recover rather than wrap.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (en) begin
            if (q == ONE) begin
              tc <= 1'b1;
              if (mode_r) begin
                // Reload directly so the period is exactly 'reload' cycles.
                q <= reload;
              end else begin
                q     <= '0;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              q <= q - ONE;
            end
          end
        end
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          q     <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
